// File: rtl/sync_fifo_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_if -- handshake/data bundle for sync_fifo.
//
// Parameters
//   DEPTH : number of storage words (sets the width of o_level)
//   DWID  : data width in bits
//
// Signals (directions seen from the FIFO, i.e. the slave modport)
//   i_write      in   write request
//   i_din        in   write data
//   i_read       in   read request
//   i_flush      in   synchronous flush
//   i_clr_err    in   clear sticky error flags
//   o_dout       out  read data
//   o_full       out  level == DEPTH
//   o_afull      out  level >= almost-full threshold
//   o_empty      out  level == 0
//   o_aempty     out  level <= almost-empty threshold
//   o_level      out  current word count
//   o_overflow   out  sticky: a write was rejected while full
//   o_underflow  out  sticky: a read was rejected while empty
//
// Modports
//   master : the FIFO user (drives requests, observes status)
//   slave  : the FIFO itself
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface sync_fifo_if #(
    parameter int DEPTH = 16,
    parameter int DWID  = 16
);
    localparam int LW = $clog2(DEPTH + 1);

    logic            i_write;
    logic [DWID-1:0] i_din;
    logic            i_read;
    logic            i_flush;
    logic            i_clr_err;
    logic [DWID-1:0] o_dout;
    logic            o_full;
    logic            o_afull;
    logic            o_empty;
    logic            o_aempty;
    logic [LW-1:0]   o_level;
    logic            o_overflow;
    logic            o_underflow;

    modport master (
        output i_write, i_din, i_read, i_flush, i_clr_err,
        input  o_dout, o_full, o_afull, o_empty, o_aempty, o_level,
               o_overflow, o_underflow
    );

    modport slave (
        input  i_write, i_din, i_read, i_flush, i_clr_err,
        output o_dout, o_full, o_afull, o_empty, o_aempty, o_level,
               o_overflow, o_underflow
    );
endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo -- single-clock FIFO with registered status flags, sticky
// overflow/underflow errors and a synchronous flush.
//
// Parameters
//   DEPTH      : storage words, any integer >= 2 (not restricted to 2^n)
//   DWID       : data width in bits
//   AFULL_LVL  : o_afull asserts when level >= AFULL_LVL
//   AEMPTY_LVL : o_aempty asserts when level <= AEMPTY_LVL
//
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous, active-low reset
//   bus   : sync_fifo_if.slave (requests in, data/status out)
//
// Build option
//   SYNC_FIFO_FWFT_EN : when defined, first-word-fall-through -- o_dout always
//                       shows the head word while non-empty (zero when empty).
//                       When undefined, o_dout is loaded with the popped word
//                       on the edge that accepts a read and holds otherwise.
//                       Level, flags and their latencies are the same in both.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sync_fifo #(
    parameter int DEPTH      = 16,
    parameter int DWID       = 16,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    sync_fifo_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    // Pointer advance with an explicit wrap, so non power-of-two depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [DWID-1:0] mem [DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q,  level_d;
    logic            full_q,   full_d;
    logic            afull_q,  afull_d;
    logic            empty_q,  empty_d;
    logic            aempty_q, aempty_d;
    logic            ovf_q,    ovf_d;
    logic            unf_q,    unf_d;
    logic [DWID-1:0] dout_q,   dout_d;

    logic wr_acc;
    logic rd_acc;
    logic wr_en;
    logic rd_en;

    // Acceptance is decided from the registered flags; flush then vetoes any
    // state change caused by an accepted request.
    assign wr_acc = bus.i_write && !full_q;
    assign rd_acc = bus.i_read  && !empty_q;
    assign wr_en  = wr_acc && !bus.i_flush;
    assign rd_en  = rd_acc && !bus.i_flush;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (bus.i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({wr_en, rd_en})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // Flags are registered from the next level so they line up with o_level.
    always_comb begin
        full_d   = (level_d == LW'(DEPTH));
        empty_d  = (level_d == '0);
        afull_d  = (int'(level_d) >= AFULL_LVL);
        aempty_d = (int'(level_d) <= AEMPTY_LVL);
    end

    // A fresh error wins over a same-cycle clear; a flushed request is
    // discarded without being treated as an error.
    always_comb begin
        ovf_d = (bus.i_write && full_q  && !bus.i_flush) || (ovf_q && !bus.i_clr_err);
        unf_d = (bus.i_read  && empty_q && !bus.i_flush) || (unf_q && !bus.i_clr_err);
    end

`ifdef SYNC_FIFO_FWFT_EN
    // o_dout tracks the head word that will exist after this edge.
    always_comb begin
        dout_d = dout_q;
        if (bus.i_flush || (level_d == '0)) begin
            dout_d = '0;
        end else if (empty_q) begin
            // Only a write can make an empty FIFO non-empty.
            dout_d = bus.i_din;
        end else if (rd_en) begin
            // With one word left, the new head is the word being written now.
            dout_d = (level_q == LW'(1)) ? bus.i_din : mem[ptr_inc(rd_ptr_q)];
        end
    end
`else
    always_comb begin
        dout_d = dout_q;
        if (rd_en) dout_d = mem[rd_ptr_q];
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dout_q   <= dout_d;
        end
    end

    // NOTE: the storage array has no reset; pointers and level define which
    // words are valid, so clearing it would only cost a reset tree.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= bus.i_din;
    end

    assign bus.o_dout      = dout_q;
    assign bus.o_full      = full_q;
    assign bus.o_afull     = afull_q;
    assign bus.o_empty     = empty_q;
    assign bus.o_aempty    = aempty_q;
    assign bus.o_level     = level_q;
    assign bus.o_overflow  = ovf_q;
    assign bus.o_underflow = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo -- directed self-checking bench for sync_fifo
// (DEPTH=8, DWID=16, AFULL_LVL=6, AEMPTY_LVL=2). Works in both output modes;
// define SYNC_FIFO_FWFT_EN for the bench and RTL together.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sync_fifo;
    localparam int DEPTH = 8;
    localparam int DWID  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_if #(.DEPTH(DEPTH), .DWID(DWID)) bus ();

    sync_fifo #(
        .DEPTH      (DEPTH),
        .DWID       (DWID),
        .AFULL_LVL  (6),
        .AEMPTY_LVL (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [DWID-1:0] model_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_write   = 1'b0;
        bus.i_din     = '0;
        bus.i_read    = 1'b0;
        bus.i_flush   = 1'b0;
        bus.i_clr_err = 1'b0;
    endtask

    // One clock with the given requests; the queue decides acceptance from
    // the pre-edge word count and supplies the expected data and level.
    task automatic cycle(input logic w, input logic [DWID-1:0] d, input logic r);
        logic            push_ok;
        logic            pop_ok;
        logic [DWID-1:0] exp_pop;
        push_ok = w && (model_q.size() < DEPTH);
        pop_ok  = r && (model_q.size() > 0);
        exp_pop = '0;
`ifdef SYNC_FIFO_FWFT_EN
        if (model_q.size() > 0) check("fwft_head", 32'(bus.o_dout), 32'(model_q[0]));
`endif
        if (pop_ok) exp_pop = model_q.pop_front();
        if (push_ok) model_q.push_back(d);
        bus.i_write = w;
        bus.i_din   = d;
        bus.i_read  = r;
        step();
        clear_inputs();
        check("level", 32'(bus.o_level), 32'(model_q.size()));
`ifndef SYNC_FIFO_FWFT_EN
        if (pop_ok) check("dout", 32'(bus.o_dout), 32'(exp_pop));
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_level"}, 32'(bus.o_level),     0);
        check({tag, "_empty"}, 32'(bus.o_empty),     1);
        check({tag, "_aempt"}, 32'(bus.o_aempty),    1);
        check({tag, "_full"},  32'(bus.o_full),      0);
        check({tag, "_afull"}, 32'(bus.o_afull),     0);
        check({tag, "_ovf"},   32'(bus.o_overflow),  0);
        check({tag, "_unf"},   32'(bus.o_underflow), 0);
        check({tag, "_dout"},  32'(bus.o_dout),      0);
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #12;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step();

        // Fill 1..8: flags against the level after each write.
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, DWID'(i), 1'b0);
            check("fill_full",  32'(bus.o_full),   32'(i == DEPTH));
            check("fill_afull", 32'(bus.o_afull),  32'(i >= 6));
            check("fill_aempt", 32'(bus.o_aempty), 32'(i <= 2));
            check("fill_empty", 32'(bus.o_empty),  0);
        end
        // Write into a full FIFO: rejected and flagged.
        cycle(1'b1, 16'h0009, 1'b0);
        check("ovf_set",  32'(bus.o_overflow), 1);
        check("ovf_full", 32'(bus.o_full),     1);

        // Drain: words must come out as 1..8, then underflow on the 9th read.
        for (int i = 1; i <= DEPTH; i++) cycle(1'b0, '0, 1'b1);
        check("drain_empty", 32'(bus.o_empty),  1);
        check("drain_aempt", 32'(bus.o_aempty), 1);
        cycle(1'b0, '0, 1'b1);
        check("unf_set",    32'(bus.o_underflow), 1);
        check("ovf_sticky", 32'(bus.o_overflow),  1);
`ifdef SYNC_FIFO_FWFT_EN
        check("unf_dout", 32'(bus.o_dout), 0);
`else
        check("unf_dout", 32'(bus.o_dout), 32'h0008);
`endif
        bus.i_clr_err = 1'b1;
        step();
        clear_inputs();
        check("clr_ovf", 32'(bus.o_overflow),  0);
        check("clr_unf", 32'(bus.o_underflow), 0);

        // New error in the same cycle as the clear keeps the flag set.
        bus.i_read    = 1'b1;
        bus.i_clr_err = 1'b1;
        step();
        clear_inputs();
        check("clr_race_unf", 32'(bus.o_underflow), 1);
        check("clr_race_ovf", 32'(bus.o_overflow),  0);
        bus.i_clr_err = 1'b1;
        step();
        clear_inputs();
        check("clr2_unf", 32'(bus.o_underflow), 0);

        // Level 4, read+write every cycle across pointer wrap.
        for (int k = 0; k < 4; k++) cycle(1'b1, DWID'(16'h0100 + k), 1'b0);
        for (int k = 0; k < 20; k++) cycle(1'b1, DWID'(16'h0200 + k), 1'b1);
        check("rw_level", 32'(bus.o_level), 4);
        for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b1);
        check("rw_empty", 32'(bus.o_empty), 1);

        // Level 5, flush with a concurrent write.
        for (int k = 0; k < 5; k++) cycle(1'b1, DWID'(16'h0300 + k), 1'b0);
        bus.i_flush = 1'b1;
        bus.i_write = 1'b1;
        bus.i_din   = 16'hDEAD;
        step();
        clear_inputs();
        model_q.delete();
        check("flush_level", 32'(bus.o_level),    0);
        check("flush_empty", 32'(bus.o_empty),    1);
        check("flush_aempt", 32'(bus.o_aempty),   1);
        check("flush_full",  32'(bus.o_full),     0);
        check("flush_afull", 32'(bus.o_afull),    0);
        check("flush_ovf",   32'(bus.o_overflow), 0);
        cycle(1'b1, 16'h1234, 1'b0);
        cycle(1'b0, '0, 1'b1);

        // Flush while full with a write: no overflow.
        for (int k = 0; k < DEPTH; k++) cycle(1'b1, DWID'(16'h0400 + k), 1'b0);
        bus.i_flush = 1'b1;
        bus.i_write = 1'b1;
        step();
        clear_inputs();
        model_q.delete();
        check("flush_full_ovf", 32'(bus.o_overflow), 0);
        check("flush_full_lvl", 32'(bus.o_level),    0);

        // Full with read+write: only the read is taken, write flags overflow.
        for (int k = 0; k < DEPTH; k++) cycle(1'b1, DWID'(16'h0500 + k), 1'b0);
        cycle(1'b1, 16'h4444, 1'b1);
        check("full_rw_ovf", 32'(bus.o_overflow), 1);
        for (int k = 0; k < DEPTH - 1; k++) cycle(1'b0, '0, 1'b1);
        // Empty with read+write: only the write is taken, read flags underflow.
        cycle(1'b1, 16'h5555, 1'b1);
        check("empty_rw_unf", 32'(bus.o_underflow), 1);
        check("empty_rw_emp", 32'(bus.o_empty),     0);
        bus.i_clr_err = 1'b1;
        step();
        clear_inputs();
        cycle(1'b0, '0, 1'b1);

        // Asynchronous reset mid-burst at level 3.
        for (int k = 0; k < 4; k++) cycle(1'b1, DWID'(16'h0600 + k), 1'b0);
        cycle(1'b0, '0, 1'b1);
        bus.i_write = 1'b1;
        bus.i_din   = 16'h0777;
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        rst_n = 1'b1;
        clear_inputs();
        model_q.delete();
        cycle(1'b1, 16'hBEEF, 1'b0);
        cycle(1'b0, '0, 1'b1);
        check("post_rst_empty", 32'(bus.o_empty), 1);

        // Write into empty: o_empty falls after that edge, no read issued.
        cycle(1'b1, 16'hA5A5, 1'b0);
        check("wr_empty_emp", 32'(bus.o_empty), 0);
`ifdef SYNC_FIFO_FWFT_EN
        check("wr_empty_dout", 32'(bus.o_dout), 32'hA5A5);
`else
        check("wr_empty_dout", 32'(bus.o_dout), 32'hBEEF);
`endif
        cycle(1'b0, '0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of storage words; any integer >= 2, power of two not required.
REQ-002 SHALL have parameter DWID, default 16, data width in bits.
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-2, level at or above which o_afull asserts.
REQ-004 SHALL have parameter AEMPTY_LVL, default 2, level at or below which o_aempty asserts.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 i_write  input  1  write request.
REQ-008 i_din  input  DWID  write data.
REQ-009 i_read  input  1  read request.
REQ-010 i_flush  input  1  synchronous flush, empties FIFO.
REQ-011 i_clr_err  input  1  clears sticky error flags.
REQ-012 o_dout  output  DWID  read data.
REQ-013 o_full / o_afull  output  1 each  full / almost-full.
REQ-014 o_empty / o_aempty  output  1 each  empty / almost-empty.
REQ-015 o_level  output  $clog2(DEPTH+1)  current word count.
REQ-016 o_overflow / o_underflow  output  1 each  sticky error flags.

Function
REQ-017 Write accepted iff i_write && !o_full; read accepted iff i_read && !o_empty; evaluated on the same edge, independently.
REQ-018 All DEPTH entries SHALL be usable: o_full = (o_level == DEPTH), o_empty = (o_level == 0).
REQ-019 Write and read pointers SHALL wrap from DEPTH-1 to 0; no power-of-two assumption.
REQ-020 o_level SHALL +1 on write only, -1 on read only, hold on both or neither; never exceeds DEPTH or drops below 0.
REQ-021 Simultaneous accepted read and write SHALL be legal at any non-empty, non-full level; when full only the read is accepted, when empty only the write.
REQ-022 o_afull = (o_level >= AFULL_LVL); o_aempty = (o_level <= AEMPTY_LVL); both registered, consistent with o_level same cycle.
REQ-023 Rejected write (i_write && o_full) SHALL set o_overflow next cycle; rejected read (i_read && o_empty) SHALL set o_underflow; flags hold until i_clr_err or reset.
REQ-024 i_clr_err SHALL clear both flags next cycle; a new error in the same cycle as i_clr_err wins (flag stays set).
REQ-025 i_flush SHALL, next cycle, zero both pointers and o_level, set o_empty/o_aempty, clear o_full/o_afull; flush overrides any same-cycle read or write (write data discarded, no error flagged); memory contents not cleared.
REQ-026 Standard mode: o_dout registered, updated with the popped word one cycle after the accepted read; holds otherwise.
REQ-027 Write into empty FIFO at edge N SHALL deassert o_empty after edge N.

Reset
REQ-028 rst_n low SHALL immediately force: pointers 0, o_level 0, o_empty 1, o_aempty 1, o_full 0, o_afull 0, o_overflow 0, o_underflow 0, o_dout 0.
REQ-029 Reset mid-operation SHALL discard all stored words; first accepted write after release is the first word read.
REQ-030 Memory array SHALL not be reset.

Configuration
REQ-031 Macro SYNC_FIFO_FWFT_EN defined: first-word-fall-through; o_dout SHALL show the head word whenever !o_empty, valid the cycle o_empty falls; accepted read advances o_dout to next word next cycle (or o_empty rises); o_dout value undefined-but-stable-zero when empty.
REQ-032 Macro undefined: standard mode per REQ-026; o_level, flags and latencies of REQ-027 identical in both modes.

Verification (DEPTH=8, DWID=16, AFULL_LVL=6, AEMPTY_LVL=2)
REQ-033 Reset, write 0x0001..0x0008 -> o_full=1 after 8th write, o_level=8, o_afull from level 6, o_aempty cleared at level 3; 9th write -> o_overflow=1, contents unchanged.
REQ-034 Read 8 words (standard) -> o_dout 0x0001..0x0008 each one cycle after read; 9th read -> o_underflow=1; i_clr_err -> both flags 0.
REQ-035 Level 4, read+write every cycle for 20 cycles -> o_level stays 4, data order preserved across pointer wrap.
REQ-036 Level 5, i_flush with i_write=1 -> next cycle o_level=0, o_empty=1, o_overflow=0; next write/read returns new data only.
REQ-037 rst_n low for 1 ns mid-burst at level 3 -> outputs per REQ-028 immediately; after release, write 0xBEEF, read -> 0xBEEF.
REQ-038 With SYNC_FIFO_FWFT_EN: write 0xA5A5 into empty -> next cycle o_empty=0, o_dout=0xA5A5 without a read.
